// File: rtl/pipe_redirect_ctrl_if.sv
// Redirect-control bundle between the hazard unit (master) and pipe_redirect_ctrl (slave).
interface pipe_redirect_ctrl_if #(
    parameter int unsigned AW    = 32,
    parameter int unsigned CNT_W = 16
);
    logic             br_take;
    logic [AW-1:0]    br_target;
    logic             exc_req;
    logic [AW-1:0]    exc_target;
    logic             stall_in;
    logic             pc_load;
    logic [AW-1:0]    pc_target;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_exmem;
    logic             stall_out;
    logic             busy;
    logic [CNT_W-1:0] redir_cnt;

    modport master (
        output br_take, br_target, exc_req, exc_target, stall_in,
        input  pc_load, pc_target, flush_ifid, flush_idex, flush_exmem,
               stall_out, busy, redir_cnt
    );

    modport slave (
        input  br_take, br_target, exc_req, exc_target, stall_in,
        output pc_load, pc_target, flush_ifid, flush_idex, flush_exmem,
               stall_out, busy, redir_cnt
    );
endinterface

// File: rtl/pipe_redirect_ctrl.sv
// Turns resolved branch/exception redirects into a PC-load pulse, registered target and
// per-stage flush windows; redirects always win over the load-use stall.
module pipe_redirect_ctrl #(
    parameter int unsigned AW        = 32,
    parameter int unsigned BR_DEPTH  = 3,
    parameter int unsigned EXC_DEPTH = 3,
    parameter int unsigned CNT_W     = 16
) (
    input logic                clk,
    input logic                rst_n,
    pipe_redirect_ctrl_if.slave rif
);
    localparam int unsigned MAX_DEPTH = (BR_DEPTH > EXC_DEPTH) ? BR_DEPTH : EXC_DEPTH;
    localparam int unsigned CW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [CW-1:0] BR_INIT  = CW'(BR_DEPTH - 1);
    localparam logic [CW-1:0] EXC_INIT = CW'(EXC_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH_BR,
        FLUSH_EXC
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pc_load_q, pc_load_d;
    logic [AW-1:0]    pc_target_q, pc_target_d;
    logic             flush_ifid_q, flush_ifid_d;
    logic             flush_idex_q, flush_idex_d;
    logic             flush_exmem_q, flush_exmem_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
    logic             accept;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_load_d     = 1'b0;
        pc_target_d   = pc_target_q;
        flush_ifid_d  = flush_ifid_q;
        flush_idex_d  = flush_idex_q;
        flush_exmem_d = flush_exmem_q;
        busy_d        = busy_q;
        redir_cnt_d   = redir_cnt_q;
        accept        = 1'b0;

        case (state_q)
            IDLE: accept = 1'b1;
            FLUSH_BR, FLUSH_EXC: begin
                // A stall freezes the whole window, including its final cycle.
                if (!rif.stall_in) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d       = IDLE;
                        flush_ifid_d  = 1'b0;
                        flush_idex_d  = 1'b0;
                        flush_exmem_d = 1'b0;
                        busy_d        = 1'b0;
                        accept        = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Exception has priority; a request on the window's closing edge starts a new one.
        if (accept && (rif.exc_req || rif.br_take)) begin
            pc_load_d     = 1'b1;
            flush_ifid_d  = 1'b1;
            flush_idex_d  = 1'b1;
            busy_d        = 1'b1;
            redir_cnt_d   = (redir_cnt_q == '1) ? redir_cnt_q : redir_cnt_q + 1'b1;
            if (rif.exc_req) begin
                state_d       = FLUSH_EXC;
                cnt_d         = EXC_INIT;
                pc_target_d   = rif.exc_target;
                flush_exmem_d = 1'b1;
            end else begin
                state_d       = FLUSH_BR;
                cnt_d         = BR_INIT;
                pc_target_d   = rif.br_target;
                flush_exmem_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pc_load_q     <= 1'b0;
            pc_target_q   <= '0;
            flush_ifid_q  <= 1'b0;
            flush_idex_q  <= 1'b0;
            flush_exmem_q <= 1'b0;
            busy_q        <= 1'b0;
            redir_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_load_q     <= pc_load_d;
            pc_target_q   <= pc_target_d;
            flush_ifid_q  <= flush_ifid_d;
            flush_idex_q  <= flush_idex_d;
            flush_exmem_q <= flush_exmem_d;
            busy_q        <= busy_d;
            redir_cnt_q   <= redir_cnt_d;
        end
    end

    assign rif.pc_load     = pc_load_q;
    assign rif.pc_target   = pc_target_q;
    assign rif.flush_ifid  = flush_ifid_q;
    assign rif.flush_idex  = flush_idex_q;
    assign rif.flush_exmem = flush_exmem_q;
    assign rif.busy        = busy_q;
    assign rif.redir_cnt   = redir_cnt_q;
    assign rif.stall_out   = rif.stall_in & ~busy_q & ~rif.br_take & ~rif.exc_req;
endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// Scoreboard bench for pipe_redirect_ctrl: a window-level reference model queues the expected
// outputs of each cycle and an independent monitor pops and compares them.
module tb_pipe_redirect_ctrl;
    localparam int unsigned AW        = 32;
    localparam int unsigned BR_DEPTH  = 3;
    localparam int unsigned EXC_DEPTH = 3;
    localparam int unsigned CNT_W     = 4;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    pipe_redirect_ctrl_if #(.AW(AW), .CNT_W(CNT_W)) rif ();

    pipe_redirect_ctrl #(
        .AW(AW), .BR_DEPTH(BR_DEPTH), .EXC_DEPTH(EXC_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rif(rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             pc_load;
        logic [AW-1:0]    pc_target;
        logic             flush_ifid;
        logic             flush_idex;
        logic             flush_exmem;
        logic             busy;
        logic             stall_out;
        logic [CNT_W-1:0] redir_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: remaining flush cycles of the current window and what opened it.
    int          rem    = 0;
    bit          is_exc = 0;
    bit          first  = 0;
    logic [AW-1:0] tgt  = '0;
    int          nacc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit br, input logic [AW-1:0] bt,
                         input bit exc, input logic [AW-1:0] et, input bit st);
        exp_t e;
        bit   can_accept;
        @(posedge clk);
        #1;
        rst_n          = rst;
        rif.br_take    = br;
        rif.br_target  = bt;
        rif.exc_req    = exc;
        rif.exc_target = et;
        rif.stall_in   = st;

        e.pc_load     = first;
        e.pc_target   = tgt;
        e.flush_ifid  = (rem > 0);
        e.flush_idex  = (rem > 0);
        e.flush_exmem = (rem > 0) && is_exc;
        e.busy        = (rem > 0);
        e.stall_out   = st && (rem == 0) && !br && !exc;
        e.redir_cnt   = CNT_W'(nacc);
        exp_q.push_back(e);

        if (!rst) begin
            rem = 0; is_exc = 0; first = 0; tgt = '0; nacc = 0;
        end else begin
            first      = 0;
            can_accept = (rem == 0);
            if (rem > 0 && !st) begin
                rem--;
                can_accept = (rem == 0);
            end
            if (can_accept && (exc || br)) begin
                first  = 1;
                is_exc = exc;
                tgt    = exc ? et : bt;
                rem    = exc ? EXC_DEPTH : BR_DEPTH;
                if (nacc < CNT_MAX) nacc++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, '0, 0, '0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_load",     64'(rif.pc_load),     64'(e.pc_load));
                chk("pc_target",   64'(rif.pc_target),   64'(e.pc_target));
                chk("flush_ifid",  64'(rif.flush_ifid),  64'(e.flush_ifid));
                chk("flush_idex",  64'(rif.flush_idex),  64'(e.flush_idex));
                chk("flush_exmem", 64'(rif.flush_exmem), 64'(e.flush_exmem));
                chk("busy",        64'(rif.busy),        64'(e.busy));
                chk("stall_out",   64'(rif.stall_out),   64'(e.stall_out));
                chk("redir_cnt",   64'(rif.redir_cnt),   64'(e.redir_cnt));
            end
        end
    end

    initial begin : stimulus
        rst_n          = 1'b0;
        rif.br_take    = 1'b0;
        rif.br_target  = '0;
        rif.exc_req    = 1'b0;
        rif.exc_target = '0;
        rif.stall_in   = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then a plain branch window.
        cycle(0, 0, '0, 0, '0, 0);
        cycle(1, 1, 32'h0040_0100, 0, '0, 0);
        idle(4);

        // Simultaneous branch and exception: exception wins, counted once.
        cycle(1, 1, 32'h1234_5678, 1, 32'h0000_4180, 0);
        idle(4);

        // Branch during a window is dropped.
        cycle(1, 1, 32'h0000_0a00, 0, '0, 0);
        idle(1);
        cycle(1, 1, 32'h0000_0b00, 0, '0, 0);
        idle(3);

        // Stall mid-window lengthens it; stall_out held low while busy.
        cycle(1, 1, 32'h0000_0c00, 0, '0, 0);
        idle(1);
        cycle(1, 0, '0, 0, '0, 1);
        cycle(1, 0, '0, 0, '0, 1);
        idle(4);
        cycle(1, 0, '0, 0, '0, 1);

        // Reset during the second flush cycle.
        cycle(1, 1, 32'h0000_0d00, 0, '0, 0);
        idle(1);
        cycle(0, 0, '0, 0, '0, 0);
        idle(2);

        // Back-to-back branches saturate the 4-bit counter.
        for (int i = 0; i < 17 * BR_DEPTH + 2; i++)
            cycle(1, 1, AW'($urandom), 0, '0, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) >= 2),
                  ($urandom_range(0, 99) < 30), AW'($urandom),
                  ($urandom_range(0, 99) < 10), AW'($urandom),
                  ($urandom_range(0, 99) < 25));
            if (i == 1500) begin
                cycle(0, 0, '0, 0, '0, 0);
                for (int j = 0; j < 20; j++) cycle(1, 0, '0, 1, AW'($urandom), 0);
            end
        end
        idle(3);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
